// File: rtl/pulse_evt_pkg.sv
// pulse_evt_pkg
// Shared definitions for the pulse event logger:
//   - default sizing constants (timestamp width, FIFO depth, minimum pulse
//     spacing, statistics counter width)
//   - the logical layout of one logged event
//   - a saturating increment helper used by the statistics counters
`timescale 1ns/1ps
package pulse_evt_pkg;

    localparam int TS_W_DEF    = 16;
    localparam int DEPTH_DEF   = 8;
    localparam int GAP_MIN_DEF = 4;
    localparam int CNT_W_DEF   = 8;

    // One logged event at the default timestamp width. The top level packs
    // the same fields as {close, ts} into a flat FIFO word so that it can
    // follow a non-default TS_W.
    typedef struct packed {
        logic [TS_W_DEF-1:0] ts;
        logic                close;
    } evt_entry_t;

    // Increment val, holding at the all-ones value of a width-bit counter.
    // width must be between 1 and 32.
    function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                            input int unsigned width);
        logic [32:0] max_val;
        max_val = (33'd1 << width) - 33'd1;
        return (val == max_val[31:0]) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft
// Single-clock first-word-fall-through FIFO. The head entry is presented
// combinationally on rdata whenever empty=0.
// Ports:
//   clk, rst       clock and synchronous active-high reset (clears pointers)
//   push, wdata    write wdata at the tail (caller must not push when full
//                  unless it pops in the same cycle)
//   pop            discard the head entry (caller must not pop when empty)
//   rdata          head entry
//   full, empty    occupancy flags
//   level          current occupancy, 0..DEPTH
`timescale 1ns/1ps
module sync_fifo_fwft #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
        end
    end

    // When full, a simultaneous push/pop writes the slot being popped; the
    // old value is still read out this cycle, so this is safe.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr_reg[AW-1:0]];
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign level = wr_ptr_reg - rd_ptr_reg;

endmodule

// File: rtl/pulse_evt_logger.sv
// pulse_evt_logger
// Timestamps each high cycle of sync_pulse with a free-running counter,
// marks events that follow the previous pulse by fewer than GAP_MIN cycles,
// queues them in a FWFT FIFO and offers them on a valid/ready interface.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   sync_pulse               one event per high cycle
//   evt_valid / evt_ready    head-entry handshake (pop on valid && ready)
//   evt_ts, evt_close        head-entry fields, meaningful only when valid
//   evt_count, drop_count    saturating accepted / dropped pulse counts
//   fifo_full, fifo_level    FIFO occupancy
`timescale 1ns/1ps
module pulse_evt_logger
    import pulse_evt_pkg::*;
#(
    parameter int TS_W    = TS_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int GAP_MIN = GAP_MIN_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sync_pulse,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [TS_W-1:0]          evt_ts,
    output logic                     evt_close,
    output logic [CNT_W-1:0]         evt_count,
    output logic [CNT_W-1:0]         drop_count,
    output logic                     fifo_full,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int GW = $clog2(GAP_MIN + 1);
    localparam logic [GW-1:0]   GAP_SAT = GW'(GAP_MIN);
    localparam logic [GW-1:0]   GAP_ONE = GW'(1);
    localparam logic [TS_W-1:0] TS_ONE  = TS_W'(1);

    logic [TS_W-1:0]  ts_cnt_reg;
    logic [GW-1:0]    gap_cnt_reg;
    logic             have_prev_reg;
    logic [CNT_W-1:0] evt_count_reg;
    logic [CNT_W-1:0] drop_count_reg;

    logic             pop;
    logic             push;
    logic             drop;
    logic             close_bit;
    logic             fifo_empty;
    logic [TS_W:0]    fifo_wdata;
    logic [TS_W:0]    fifo_rdata;

    assign evt_valid = !fifo_empty;
    assign pop       = evt_valid && evt_ready;
    // A full FIFO still accepts a pulse if the head leaves in the same cycle.
    assign push      = sync_pulse && (!fifo_full || pop);
    assign drop      = sync_pulse && fifo_full && !pop;

    // gap_cnt saturates at GAP_MIN, so "< GAP_MIN" means the previous pulse
    // was fewer than GAP_MIN cycles ago.
    assign close_bit  = have_prev_reg && (gap_cnt_reg < GAP_SAT);
    assign fifo_wdata = {close_bit, ts_cnt_reg};

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_cnt_reg     <= '0;
            gap_cnt_reg    <= GAP_SAT;
            have_prev_reg  <= 1'b0;
            evt_count_reg  <= '0;
            drop_count_reg <= '0;
        end else begin
            ts_cnt_reg <= ts_cnt_reg + TS_ONE;

            if (sync_pulse) begin
                gap_cnt_reg   <= GAP_ONE;
                have_prev_reg <= 1'b1;
            end else if (gap_cnt_reg < GAP_SAT) begin
                gap_cnt_reg <= gap_cnt_reg + GAP_ONE;
            end

            if (push) begin
                evt_count_reg <= CNT_W'(sat_inc(32'(evt_count_reg), CNT_W));
            end
            if (drop) begin
                drop_count_reg <= CNT_W'(sat_inc(32'(drop_count_reg), CNT_W));
            end
        end
    end

    sync_fifo_fwft #(
        .WIDTH (TS_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign evt_ts     = fifo_rdata[TS_W-1:0];
    assign evt_close  = fifo_rdata[TS_W];
    assign evt_count  = evt_count_reg;
    assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_pulse_evt_logger.sv
`timescale 1ns/1ps
module tb_pulse_evt_logger;

    localparam int TS_W    = 16;
    localparam int DEPTH   = 8;
    localparam int GAP_MIN = 4;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance (default parameters)
    logic             rst, sync_pulse, evt_ready;
    logic             evt_valid, evt_close, fifo_full;
    logic [TS_W-1:0]  evt_ts;
    logic [CNT_W-1:0] evt_count, drop_count;
    logic [3:0]       fifo_level;

    // narrow-timestamp instance for wrap checks
    logic             rst4, pulse4, ready4;
    logic             evt_valid4, evt_close4, fifo_full4;
    logic [3:0]       evt_ts4;
    logic [CNT_W-1:0] evt_count4, drop_count4;
    logic [3:0]       fifo_level4;

    pulse_evt_logger dut (
        .clk(clk), .rst(rst), .sync_pulse(sync_pulse),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_ts(evt_ts), .evt_close(evt_close),
        .evt_count(evt_count), .drop_count(drop_count),
        .fifo_full(fifo_full), .fifo_level(fifo_level)
    );

    pulse_evt_logger #(.TS_W(4)) dut4 (
        .clk(clk), .rst(rst4), .sync_pulse(pulse4),
        .evt_valid(evt_valid4), .evt_ready(ready4),
        .evt_ts(evt_ts4), .evt_close(evt_close4),
        .evt_count(evt_count4), .drop_count(drop_count4),
        .fifo_full(fifo_full4), .fifo_level(fifo_level4)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (main instance) ----------------
    typedef struct {
        int ts;
        bit close;
    } ment_t;

    ment_t mq[$];
    int    m_cycle = 0;   // cycles since reset == expected timestamp (unwrapped)
    int    m_last  = 0;   // cycle of the most recent pulse
    bit    m_have  = 0;
    int    m_evt   = 0;
    int    m_drop  = 0;
    bit    m_pop, m_full;
    ment_t m_e;
    bit    chk_en = 0;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_cycle = 0;
            m_have  = 0;
            m_evt   = 0;
            m_drop  = 0;
        end else begin
            m_pop  = (mq.size() > 0) && evt_ready;
            m_full = (mq.size() == DEPTH);
            if (m_pop) void'(mq.pop_front());
            if (sync_pulse) begin
                m_e.ts    = m_cycle % (1 << TS_W);
                m_e.close = m_have && ((m_cycle - m_last) < GAP_MIN);
                if (!m_full || m_pop) begin
                    mq.push_back(m_e);
                    if (m_evt < CNT_MAX) m_evt++;
                end else if (m_drop < CNT_MAX) begin
                    m_drop++;
                end
                m_last = m_cycle;
                m_have = 1;
            end
            m_cycle++;
        end
    end

    // compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("evt_valid", evt_valid, mq.size() > 0);
            if (mq.size() > 0) begin
                chk("evt_ts", evt_ts, mq[0].ts);
                chk("evt_close", evt_close, mq[0].close);
            end
            chk("evt_count", evt_count, m_evt);
            chk("drop_count", drop_count, m_drop);
            chk("fifo_full", fifo_full, mq.size() == DEPTH);
            chk("fifo_level", fifo_level, mq.size());
        end
    end

    // cycle counter for the narrow instance
    int c4 = 0;
    always @(posedge clk) begin
        if (rst4) c4 = 0;
        else      c4++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_cyc(input int c);
        for (int i = 0; i < 2000 && m_cycle != c; i++) tick();
        if (m_cycle != c) begin
            checks++;
            errors++;
            $display("FAIL wait_cyc: got %0d expected %0d", m_cycle, c);
        end
    endtask

    task automatic pulse_at(input int c);
        wait_cyc(c);
        sync_pulse = 1'b1;
        tick();
        sync_pulse = 1'b0;
    endtask

    int exp_ts2[4]    = '{20, 22, 40, 44};
    int exp_close2[4] = '{0, 1, 0, 0};
    int t0, t_new, pct_p, pct_r;

    initial begin
        rst = 1'b1; sync_pulse = 1'b0; evt_ready = 1'b0;
        rst4 = 1'b1; pulse4 = 1'b0; ready4 = 1'b0;
        @(negedge clk);
        tick();
        chk_en = 1;
        tick();
        chk("reset evt_valid", evt_valid, 0);
        chk("reset fifo_level", fifo_level, 0);
        chk("reset evt_count", evt_count, 0);
        chk("reset evt_valid4", evt_valid4, 0);
        rst = 1'b0; rst4 = 1'b0;

        // timestamp wrap on the 4-bit instance
        for (int i = 0; i < 100 && c4 != 15; i++) tick();
        pulse4 = 1'b1; tick(); pulse4 = 1'b0;
        for (int i = 0; i < 100 && c4 != 20; i++) tick();
        pulse4 = 1'b1; tick(); pulse4 = 1'b0;
        chk("t5 level", fifo_level4, 2);
        chk("t5 ts0", evt_ts4, 15);
        chk("t5 close0", evt_close4, 0);
        ready4 = 1'b1; tick(); ready4 = 1'b0;
        chk("t5 ts1", evt_ts4, 4);
        chk("t5 close1", evt_close4, 0);
        $display("wrap: 4-bit instance produced timestamps 15 then 4");

        // single pulse at ts 10
        do_reset();
        evt_ready = 1'b1;
        pulse_at(10);
        chk("t1 valid", evt_valid, 1);
        chk("t1 ts", evt_ts, 10);
        chk("t1 close", evt_close, 0);
        chk("t1 count", evt_count, 1);
        tick();
        chk("t1 valid after pop", evt_valid, 0);
        $display("single pulse at ts 10 logged and consumed");

        // spacing bits
        evt_ready = 1'b0;
        pulse_at(20); pulse_at(22); pulse_at(40); pulse_at(44);
        for (int i = 0; i < 4; i++) begin
            chk("t2 valid", evt_valid, 1);
            chk("t2 ts", evt_ts, exp_ts2[i]);
            chk("t2 close", evt_close, exp_close2[i]);
            evt_ready = 1'b1; tick(); evt_ready = 1'b0;
        end
        chk("t2 drained", evt_valid, 0);
        $display("spacing: four pulses drained with close bits 0 1 0 0");

        // overflow with nine pulses
        do_reset();
        t0 = m_cycle;
        sync_pulse = 1'b1;
        repeat (9) tick();
        sync_pulse = 1'b0;
        chk("t3 full", fifo_full, 1);
        chk("t3 level", fifo_level, 8);
        chk("t3 count", evt_count, 8);
        chk("t3 drop", drop_count, 1);
        for (int i = 0; i < 8; i++) begin
            chk("t3 drain ts", evt_ts, t0 + i);
            evt_ready = 1'b1; tick(); evt_ready = 1'b0;
        end
        $display("overflow: 8 kept, 1 dropped, drained in order");

        // push and pop in the same cycle while full
        do_reset();
        sync_pulse = 1'b1;
        repeat (8) tick();
        chk("t4 full before", fifo_full, 1);
        t_new = m_cycle;
        evt_ready = 1'b1;
        tick();
        sync_pulse = 1'b0; evt_ready = 1'b0;
        chk("t4 level", fifo_level, 8);
        chk("t4 drop", drop_count, 0);
        chk("t4 count", evt_count, 9);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("t4 tail ts", evt_ts, t_new);
            evt_ready = 1'b1; tick(); evt_ready = 1'b0;
        end
        $display("full push+pop: no drop, new entry at tail");

        // reset in the middle of a pulse burst
        do_reset();
        sync_pulse = 1'b1;
        repeat (3) tick();
        chk("t6 level before", fifo_level, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0; sync_pulse = 1'b0;
        chk("t6 valid", evt_valid, 0);
        chk("t6 level", fifo_level, 0);
        chk("t6 count", evt_count, 0);
        chk("t6 drop", drop_count, 0);
        tick();
        sync_pulse = 1'b1; tick(); sync_pulse = 1'b0;
        chk("t6 close", evt_close, 0);
        chk("t6 count after", evt_count, 1);
        $display("mid-burst reset cleared FIFO and counters");

        // randomized traffic, then a drop-heavy phase to saturate counters
        for (int i = 0; i < 3000; i++) begin
            pct_p = (i < 1500) ? 40 : 75;
            pct_r = (i < 1500) ? 55 : 10;
            sync_pulse = ($urandom_range(0, 99) < pct_p);
            evt_ready  = ($urandom_range(0, 99) < pct_r);
            rst        = (i < 1000) && ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0; sync_pulse = 1'b0; evt_ready = 1'b0;
        chk("sat evt_count", evt_count, CNT_MAX);
        chk("sat drop_count", drop_count, CNT_MAX);
        $display("random: 3000 cycles of traffic compared against model");

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_evt_logger.md
Name: pulse_evt_logger

Overview:
- Consumer stage directly downstream of the narrow-pulse detector in the multi-bit fast-to-slow CDC path.
- Takes the detector's single-cycle `sync_pulse` in the destination (`clk`) domain and timestamps each event with a free-running counter.
- Buffers events in a small FIFO and presents them on a valid/ready interface for software/registers.
- Keeps saturating accept/drop counters and flags events that arrive closer together than a configured minimum spacing.

Parameters:
- TS_W, 16: timestamp width; the free-running counter wraps at 2^TS_W.
- DEPTH, 8: FIFO depth in entries; must be a power of 2 and at least 2.
- GAP_MIN, 4: minimum legal spacing in clk cycles between consecutive pulses; must be at least 2.
- CNT_W, 8: width of the saturating event and drop counters.

Ports:
- clk  in  1  destination-domain clock.
- rst  in  1  synchronous, active-high reset.
- sync_pulse  in  1  event strobe from the narrow-pulse detector; each high cycle is one event.
- evt_valid  out  1  FIFO head entry valid.
- evt_ready  in  1  consumer accepts the head entry.
- evt_ts  out  TS_W  timestamp of the head entry.
- evt_close  out  1  head entry arrived less than GAP_MIN cycles after the previous pulse.
- evt_count  out  CNT_W  pulses written into the FIFO; saturating.
- drop_count  out  CNT_W  pulses lost because the FIFO was full; saturating.
- fifo_full  out  1  FIFO holds DEPTH entries.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: ts_cnt=0, FIFO pointers=0, evt_valid=0, fifo_full=0, fifo_level=0, evt_count=0, drop_count=0, have_prev=0, gap_cnt=GAP_MIN.
- evt_ts and evt_close are don't-care while evt_valid=0. The bench must not check them then.
- ts_cnt increments by 1 every cycle and wraps from 2^TS_W-1 to 0 with no flag.
- Capture: if sync_pulse=1 in cycle t, the entry stores ts = ts_cnt value in cycle t.
- Latency: the entry is visible at the head (evt_valid=1, if the FIFO was empty) in cycle t+1.
- FIFO is first-word-fall-through. evt_ts and evt_close are driven combinationally from mem[rd_ptr].
- Pop occurs when evt_valid && evt_ready.
- Push occurs when sync_pulse && (!fifo_full || pop).
  - When full, a pop in the same cycle frees the slot, so the push is accepted and the level is unchanged.
- Drop occurs when sync_pulse && fifo_full && !pop. drop_count increments (saturating at 2^CNT_W-1); no FIFO change.
- evt_count increments (saturating) on every push.
- Simultaneous push and pop when not full or empty: level unchanged, both pointers advance.
- Pop on empty is impossible, because evt_valid=0.
- Pointers are $clog2(DEPTH)+1 bits wide.
  - fifo_full = (MSBs differ && LSBs equal).
  - fifo_level = wr_ptr - rd_ptr.
- Spacing check:
  - gap_cnt is set to 1 on any pulse, whether pushed or dropped.
  - Otherwise gap_cnt increments, saturating at GAP_MIN.
  - Stored close bit = have_prev && (gap_cnt < GAP_MIN), evaluated in the pulse cycle.
  - have_prev is set on the first pulse.
  - Consequences: the first pulse after reset has close=0; back-to-back high cycles give close=1; pulses exactly GAP_MIN cycles apart give close=0.
- sync_pulse held high for N cycles produces N events. The block does not edge-detect.
- Reset mid-operation: FIFO content is discarded and evt_valid drops the cycle after rst is sampled high.
  - Any pulse in a cycle where rst=1 is ignored.
  - The first pulse after reset is treated as having no predecessor.
- There is no internal state machine beyond the FIFO and counters. All state changes occur only on the rising edge of clk.

Decomposition:
- Package pulse_evt_pkg holds:
  - default constants TS_W, DEPTH, GAP_MIN, CNT_W;
  - the entry struct {ts[TS_W], close};
  - a saturating-increment function for CNT_W counters.
- Sub-module sync_fifo_fwft (parameters WIDTH and DEPTH):
  - ports: push, pop, wdata, rdata, full, empty, level;
  - instantiated once with WIDTH = TS_W+1.
- Top level contains: ts counter, gap logic, push/drop arbitration and stat counters.

Test Plan:
1. Single pulse after reset, at ts_cnt=10, with evt_ready=1 → evt_valid=1 one cycle later, evt_ts=10, evt_close=0, evt_count=1, then evt_valid=0.
2. Pulses at ts 20 and 22 (GAP_MIN=4), then pulses at ts 40 and 44 → close bits 0, 1, 0, 0 in FIFO order.
3. evt_ready=0 with 9 single-cycle pulses → fifo_full=1, fifo_level=8, evt_count=8, drop_count=1; draining returns the 8 oldest timestamps in order.
4. FIFO full, then pulse and pop in the same cycle → no drop, fifo_level stays 8, and the new entry lands at the tail.
5. TS_W=4: pulses at ts_cnt=15 and at 20 cycles (mod 16 = 4) → evt_ts 15 then 4; no error.
6. Three entries queued, rst asserted one cycle mid-pulse → next cycle evt_valid=0, fifo_level=0, counters=0; the next pulse reports close=0.
